// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier
// Purpose  : Sequential radix-2 Booth signed multiplier, one iteration/clock.
// Options  : BOOTH_MULTIPLIER_BUSY_EN adds the 'busy' output (high in RUN).
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
`ifdef BOOTH_MULTIPLIER_BUSY_EN
  ,
  output logic                 busy
`endif
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH:0]       r_a;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [WIDTH-1:0]     r_m;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_done;

  logic [WIDTH:0]       w_m_ext;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_a_next;
  logic [WIDTH-1:0]     w_q_next;

  // A is one bit wider than M so that subtracting -2^(WIDTH-1) cannot overflow.
  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    w_sum   = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + w_m_ext;
      2'b10:   w_sum = r_a - w_m_ext;
      default: w_sum = r_a;
    endcase
    w_a_next = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_next = {w_sum[0], r_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_m     <= M;
            r_q     <= Q;
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_result <= {w_a_next[WIDTH-1:0], w_q_next};
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

`ifdef BOOTH_MULTIPLIER_BUSY_EN
  assign busy = (r_state == S_RUN);
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_multiplier
// Purpose  : Directed self-checking bench for booth_multiplier (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [31:0]        m;
  logic [31:0]        q;
  logic [63:0]        result;
  logic               done;
`ifdef BOOTH_MULTIPLIER_BUSY_EN
  logic               busy;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [63:0] prev_result;

  booth_multiplier #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .M      (m),
    .Q      (q),
    .result (result),
    .done   (done)
`ifdef BOOTH_MULTIPLIER_BUSY_EN
    ,
    .busy   (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // hold: number of capture-relative edges start stays high;
  // midrun: inject a start pulse with other operands while running.
  task automatic do_op(input string tag, input logic signed [31:0] mv,
                       input logic signed [31:0] qv, input logic signed [63:0] exp,
                       input int hold, input bit midrun);
    int  n;
    bit  got;
    @(negedge clk);
    m = mv; q = qv; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_low_after_capture"}, 64'(done), 64'd0);
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      start = ((n + 1) < hold) || (midrun && n == 10);
      m = ~mv; q = qv ^ 32'h5A5A_A5A5;
      @(posedge clk); #1;
      n++;
      if (n == 16) check({tag, "_no_partial"}, result, prev_result);
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_result"}, result, exp);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_held"}, 64'(done), 64'd1);
    check({tag, "_result_held"}, result, exp);
    prev_result = exp;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m = '0; q = '0;
    prev_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("pos_pos", 32'sd12345, 32'sd6789, 64'sd83810205, 1, 1'b0);
    do_op("neg_pos", -32'sd12345, 32'sd6789, -64'sd83810205, 1, 1'b0);
    do_op("neg_neg", -32'sd12345, -32'sd6789, 64'sd83810205, 1, 1'b0);
    do_op("min_min", 32'sh8000_0000, 32'sh8000_0000, 64'sd4611686018427387904, 1, 1'b0);
    do_op("max_min", 32'sh7FFF_FFFF, 32'sh8000_0000, -64'sd4611686016279904256, 1, 1'b0);
    do_op("max_m1", 32'sh7FFF_FFFF, -32'sd1, -64'sd2147483647, 1, 1'b0);
    do_op("zero", 32'sd0, 32'sd123456789, 64'sd0, 1, 1'b0);
    do_op("big_neg", -32'sd12345678, 32'sd87654321, -64'sd1082152022374638, 1, 1'b0);
    do_op("hold_start", 32'sd12345, 32'sd6789, 64'sd83810205, 4, 1'b0);
    do_op("midrun_start", -32'sd12345, 32'sd6789, -64'sd83810205, 1, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    m = 32'sd987654321; q = 32'sd123456789; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_done", 64'(done), 64'd0);
    check("rst_async_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_abort_no_done", 64'(done), 64'd0);
    prev_result = '0;
    do_op("after_reset", 32'sd987654321, 32'sd123456789, 64'sd121932631112635269, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
